// File: rtl/demux_lane_deserializer_pkg.sv
// rtl/demux_lane_deserializer_pkg.sv - shared constants for the lane deserializer
//
// Purpose: lane count, select width and debug counter width shared by the
//          top level and the per-lane deserializer, plus the lane-decode helper.
// Ports:   none (package).
package demux_lane_deserializer_pkg;

  localparam int N_CH       = 4;
  localparam int SEL_W      = 2;
  localparam int DATA_W_MAX = 16;
  // Sized for the widest legal word so the debug bus layout never changes.
  localparam int CNT_W      = $clog2(DATA_W_MAX);

  // True when a valid bit is steered onto lane k.
  function automatic logic lane_hit(input logic             valid,
                                    input logic [SEL_W-1:0] sel,
                                    input logic [SEL_W-1:0] k);
    return valid && (sel == k);
  endfunction

endpackage

// File: rtl/demux_lane_deserializer_deser_lane.sv
// rtl/demux_lane_deserializer_deser_lane.sv - one lane: MSB-first shifter, holding register, sticky overflow
//
// Purpose: assembles DATA_W serial bits into a word and parks it in a
//          valid/ready holding register; words that find the holder busy are
//          dropped and flagged.
// Ports:   clk, rst     - clock, synchronous active-high reset
//          bit_in       - serial data bit
//          bit_en       - bit_in belongs to this lane this cycle
//          flush        - clear the partial word (holding register untouched)
//          ovf_clr      - clear the sticky overflow flag
//          data, valid  - holding register and its full flag
//          ready        - consumer accepts the held word this cycle
//          ovf          - sticky overflow flag
//          cnt          - bits collected toward the current word
module deser_lane
  import demux_lane_deserializer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_en,
  input  logic              flush,
  input  logic              ovf_clr,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              ovf,
  output logic [CNT_W-1:0]  cnt
);

  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;

  logic [DATA_W-1:0] word;
  logic              word_done;

  assign word      = {sr_q[DATA_W-2:0], bit_in};
  // A flushed bit never completes a word.
  assign word_done = bit_en && !flush && (cnt_q == CNT_W'(DATA_W - 1));

  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;

    if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    if (flush) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (bit_en) begin
      sr_d  = word;
      cnt_d = word_done ? '0 : cnt_q + CNT_W'(1);
    end

    if (ovf_clr) begin
      ovf_d = 1'b0;
    end

    // A word landing in the drain cycle reuses the slot; this overrides the
    // valid clear above. Overflow is evaluated last so it beats ovf_clr.
    if (word_done) begin
      if (!valid_q || ready) begin
        hold_d  = word;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data  = hold_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;
  assign cnt   = cnt_q;

endmodule

// File: rtl/demux_lane_deserializer.sv
// rtl/demux_lane_deserializer.sv - four-lane serial-to-word deserializer behind a 1:4 demux
//
// Purpose: decodes the demux select into per-lane bit enables and packs the
//          four lane outputs onto flat buses. All outputs are registered.
// Ports:   clk, rst      - clock, synchronous active-high reset
//          bit_in        - serial data bit
//          bit_valid     - bit_in and sel valid this cycle
//          sel           - lane select
//          flush[k]      - clear lane k partial word
//          ovf_clr[k]    - clear lane k overflow flag
//          out_data      - lane k word at [k*DATA_W +: DATA_W]
//          out_valid[k]  - lane k holding register full
//          out_ready[k]  - lane k consumer accepts
//          ovf[k]        - lane k sticky overflow
//          bit_cnt_dbg   - lane k bit count at [k*4 +: 4]
module demux_lane_deserializer
  import demux_lane_deserializer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH-1:0]        flush,
  input  logic [N_CH-1:0]        ovf_clr,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic [N_CH-1:0]        out_valid,
  input  logic [N_CH-1:0]        out_ready,
  output logic [N_CH-1:0]        ovf,
  output logic [N_CH*CNT_W-1:0]  bit_cnt_dbg
);

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    logic lane_en;

    assign lane_en = lane_hit(bit_valid, sel, SEL_W'(k));

    deser_lane #(
      .DATA_W (DATA_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .bit_in  (bit_in),
      .bit_en  (lane_en),
      .flush   (flush[k]),
      .ovf_clr (ovf_clr[k]),
      .data    (out_data[k*DATA_W +: DATA_W]),
      .valid   (out_valid[k]),
      .ready   (out_ready[k]),
      .ovf     (ovf[k]),
      .cnt     (bit_cnt_dbg[k*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_demux_lane_deserializer.sv
// tb/tb_demux_lane_deserializer.sv - self-checking bench for demux_lane_deserializer
module tb_demux_lane_deserializer;

  localparam int DW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        bit_in;
  logic        bit_valid;
  logic [1:0]  sel;
  logic [3:0]  flush;
  logic [3:0]  ovf_clr;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [3:0]  ovf;
  logic [15:0] bit_cnt_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  bit armed    = 1'b0;

  always #5 clk = ~clk;

  demux_lane_deserializer #(.DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .sel         (sel),
    .flush       (flush),
    .ovf_clr     (ovf_clr),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ovf         (ovf),
    .bit_cnt_dbg (bit_cnt_dbg)
  );

  // Reference model: each lane keeps the numeric value of bits received so
  // far, how many there are, and whatever word is parked for the consumer.
  int m_cnt  [4];
  int m_part [4];
  int m_hold [4];
  bit m_valid[4];
  bit m_ovf  [4];
  bit mb_loaded, mb_lost, mb_drained;

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        m_cnt[k] = 0; m_part[k] = 0; m_hold[k] = 0; m_valid[k] = 0; m_ovf[k] = 0;
      end else begin
        mb_loaded  = 0;
        mb_lost    = 0;
        mb_drained = m_valid[k] && out_ready[k];
        if (flush[k]) begin
          m_cnt[k]  = 0;
          m_part[k] = 0;
        end else if (bit_valid && sel == k) begin
          m_part[k] = (m_part[k] * 2 + int'(bit_in)) % (1 << DW);
          m_cnt[k]  = m_cnt[k] + 1;
          if (m_cnt[k] == DW) begin
            m_cnt[k] = 0;
            if (!m_valid[k] || out_ready[k]) begin
              m_hold[k] = m_part[k];
              mb_loaded = 1;
            end else begin
              mb_lost = 1;
            end
          end
        end
        if (mb_loaded) m_valid[k] = 1;
        else if (mb_drained) m_valid[k] = 0;
        if (mb_lost) m_ovf[k] = 1;
        else if (ovf_clr[k]) m_ovf[k] = 0;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("model data lane%0d", k), 32'(out_data[k*DW +: DW]), 32'(m_hold[k]));
        check($sformatf("model valid lane%0d", k), 32'(out_valid[k]), 32'(m_valid[k]));
        check($sformatf("model ovf lane%0d", k), 32'(ovf[k]), 32'(m_ovf[k]));
        check($sformatf("model cnt lane%0d", k), 32'(bit_cnt_dbg[k*4 +: 4]), 32'(m_cnt[k]));
      end
    end
  end

  task automatic idle();
    bit_valid = 1'b0;
    flush     = '0;
    ovf_clr   = '0;
  endtask

  task automatic send_bit(input int lane, input logic b);
    @(negedge clk);
    idle();
    bit_valid = 1'b1;
    sel       = 2'(lane);
    bit_in    = b;
  endtask

  task automatic send_word(input int lane, input logic [7:0] w);
    for (int i = DW - 1; i >= 0; i--) send_bit(lane, w[i]);
    @(negedge clk);
    idle();
  endtask

  task automatic drain();
    @(negedge clk);
    idle();
    out_ready = 4'hF;
    @(negedge clk);
    out_ready = 4'h0;
  endtask

  logic [7:0] wa, wb, w7e;

  initial begin
    rst = 1'b1; bit_in = 1'b0; sel = '0; out_ready = '0;
    idle();
    repeat (2) @(negedge clk);
    armed = 1'b1;
    check("reset data", out_data, 32'h0);
    check("reset valid", 32'(out_valid), 32'h0);
    check("reset cnt", 32'(bit_cnt_dbg), 32'h0);
    rst = 1'b0;

    // One word on lane 2, consumer stalled.
    send_word(2, 8'hB2);
    check("word lane2 data", 32'(out_data[23:16]), 32'hB2);
    check("word valid", 32'(out_valid), 32'b0100);
    check("word others data", {out_data[31:24], out_data[15:0]}, 32'h0);
    drain();

    // Interleaved lanes 0 and 1.
    wa = 8'hA5; wb = 8'h3C;
    for (int i = DW - 1; i >= 0; i--) begin
      send_bit(0, wa[i]);
      send_bit(1, wb[i]);
    end
    @(negedge clk); idle();
    check("interleave lane0", 32'(out_data[7:0]), 32'hA5);
    check("interleave lane1", 32'(out_data[15:8]), 32'h3C);
    check("interleave valid", 32'(out_valid), 32'b0011);
    check("interleave cnt lanes2/3", 32'(bit_cnt_dbg[15:8]), 32'h0);
    drain();

    // Overflow on lane 3 then clear.
    send_word(3, 8'h11);
    send_word(3, 8'h22);
    check("ovf lane3 data kept", 32'(out_data[31:24]), 32'h11);
    check("ovf lane3 flag", 32'(ovf), 32'b1000);
    @(negedge clk); ovf_clr = 4'b1000;
    @(negedge clk); idle();
    check("ovf lane3 cleared", 32'(ovf[3]), 32'h0);
    drain();

    // Drain and load in the same cycle on lane 0.
    send_word(0, 8'h5A);
    w7e = 8'h7E;
    for (int i = DW - 1; i >= 0; i--) begin
      send_bit(0, w7e[i]);
      if (i == 0) out_ready = 4'b0001;
    end
    @(negedge clk); idle(); out_ready = '0;
    check("drain+load valid", 32'(out_valid[0]), 32'h1);
    check("drain+load data", 32'(out_data[7:0]), 32'h7E);
    check("drain+load no ovf", 32'(ovf[0]), 32'h0);
    drain();

    // Flush mid-word on lane 1 with a concurrent bit.
    send_bit(1, 1'b1); send_bit(1, 1'b1); send_bit(1, 1'b1);
    @(negedge clk); idle();
    flush = 4'b0010; bit_valid = 1'b1; sel = 2'd1; bit_in = 1'b1;
    send_word(1, 8'hC3);
    check("flush lane1 data", 32'(out_data[15:8]), 32'hC3);
    check("flush lane1 cnt", 32'(bit_cnt_dbg[7:4]), 32'h0);
    drain();

    // Reset with lane 0 full and lane 2 at 5 bits.
    send_word(0, 8'h99);
    for (int i = 0; i < 5; i++) send_bit(2, 1'b1);
    @(negedge clk); idle();
    check("pre-reset lane2 cnt", 32'(bit_cnt_dbg[11:8]), 32'h5);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("post-reset data", out_data, 32'h0);
    check("post-reset valid", 32'(out_valid), 32'h0);
    check("post-reset cnt", 32'(bit_cnt_dbg), 32'h0);
    send_word(2, 8'h6D);
    check("post-reset lane2 word", 32'(out_data[23:16]), 32'h6D);
    check("post-reset lane2 valid", 32'(out_valid), 32'b0100);
    drain();

    // Randomized traffic with varying consumer pressure.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      bit_valid = ($urandom_range(0, 3) != 0);
      sel       = 2'($urandom);
      bit_in    = 1'($urandom);
      out_ready = ((c / 500) % 2 == 0) ? 4'($urandom) : 4'($urandom) & 4'($urandom);
      flush     = ($urandom_range(0, 31) == 0) ? 4'($urandom) : 4'h0;
      ovf_clr   = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
      rst       = ($urandom_range(0, 999) == 0);
    end
    @(negedge clk);
    idle(); rst = 1'b0; out_ready = 4'hF;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_lane_deserializer.md
# demux_lane_deserializer

Sits directly downstream of the 1:4 demux built from two-input demux cells. It consumes the serial bit stream that the demux steers onto one of four lanes. Each lane has its own shift register that assembles MSB-first bits into DATA_W-bit words. Each assembled word is presented on a per-lane valid/ready output holding register, with per-lane sticky overflow flags for words that arrive while the holding register is still occupied.

## Interface
Parameters:
- DATA_W, default 8: word width in bits; legal range 2–16.
- N_CH, fixed 4: lane count, selected by the 2-bit `sel`.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_in  input  1  serial data bit (the demux input `a`).
- bit_valid  input  1  `bit_in` and `sel` are valid this cycle.
- sel  input  2  lane select (same select that drives the demux tree).
- flush  input  4  per-lane sync clear of the partial word; does not touch the holding register.
- ovf_clr  input  4  per-lane clear of the sticky overflow flag.
- out_data  output  4*DATA_W  lane k word at [k*DATA_W +: DATA_W].
- out_valid  output  4  lane k holding register full.
- out_ready  input  4  lane k consumer accepts this cycle.
- ovf  output  4  sticky per-lane overflow.
- bit_cnt_dbg  output  4*4  per-lane count of bits collected (debug).

## Operation
Per-lane state:
- shift register `sr`, DATA_W bits.
- bit counter `cnt`, 0..DATA_W-1.
- holding register `hold` plus `out_valid`.
- `ovf` flag.

Bit capture:
- Only lane `sel` acts when `bit_valid`=1. Other lanes hold their state.
- `sr` <= {sr[DATA_W-2:0], bit_in}. The first bit received ends up at the MSB.
- `cnt` increments and wraps from DATA_W-1 to 0.
- On the wrapping bit the word is complete: word = {sr[DATA_W-2:0], bit_in}.

Word completion:
- If the holding register is free, or `out_ready` is high this cycle (the pending word drains this cycle): `hold` <= word, `out_valid` <= 1.
- Otherwise: word dropped, `hold` unchanged, `ovf[k]` <= 1.

Output handshake:
- Transfer when `out_valid[k] & out_ready[k]`.
- `out_valid` clears the next cycle unless a new word loads in the same cycle.
- `out_data` is stable while `out_valid` is high and not accepted.

Flush and overflow clear:
- `flush[k]`: `cnt` <= 0, `sr` <= 0.
- Flush takes priority over a simultaneous bit on that lane; that bit is discarded.
- `ovf_clr[k]` clears `ovf[k]`. If an overflow occurs in the same cycle, the overflow wins and `ovf[k]` stays 1.
- `sel` outside the active cycle is ignored.

## Timing
- Reset values: out_data=0, out_valid=0, ovf=0, bit_cnt_dbg=0; all `sr`/`cnt` = 0.
- Reset mid-word discards the partial word and any pending `hold`.
- Latency: last bit sampled at edge N, so `out_valid` is high after edge N (visible in cycle N+1).
- Back-to-back words on one lane need at least DATA_W valid bits, so a consumer with `out_ready` held at 1 never overflows.
- Lanes are fully independent; interleaved `sel` values per cycle are legal.
- No combinational path from inputs to outputs; all outputs are registered.

## Structure
- Shared constants header: `N_CH`, `SEL_W`=2, `CNT_W`=$clog2(DATA_W_MAX=16)=4.
- One sub-module, `deser_lane`, instantiated 4× by a generate loop. Its ports:
  - clk, rst
  - bit_in, bit_en = bit_valid & (sel==k)
  - flush, ovf_clr
  - data, valid, ready, ovf, cnt
- The top level only decodes `sel` and packs the lane outputs.

## Test plan
- **Reset, then one word:** with out_ready=0, bits 1,0,1,1,0,0,1,0 on sel=2. Expect out_data[23:16]=8'hB2, out_valid=4'b0100 one cycle after the 8th bit, other lanes 0.
- **Interleaved lanes:** alternate sel=0/1 every cycle, with lane 0 receiving 8'hA5 and lane 1 receiving 8'h3C. Expect both valid after the 16th cycle with the correct words; cnt_dbg of lanes 2/3 stays 0.
- **Overflow:** with out_ready[3]=0, send 8'h11 then 8'h22 on lane 3. Expect out_data lane 3=8'h11 retained and ovf[3]=1. Then ovf_clr[3] gives ovf[3]=0.
- **Simultaneous drain and load:** out_ready[0]=1 in the same cycle as the 8th bit of a second word 8'h7E. Expect no overflow and out_valid[0] to stay 1 with data 8'h7E.
- **Flush mid-word:** 3 bits on lane 1, flush[1] concurrent with a 4th bit, then 8 bits of 8'hC3. Expect the word 8'hC3 exactly, with no leftover bits.
- **Reset mid-operation:** rst asserted with lane 0 holding a word and lane 2 at 5 bits. Expect all outputs 0 next cycle, and the next 8 bits on lane 2 to form a fresh word.
